fetch_control: RTL and testbench

- Sequencing controller for the instruction-fetch front end: PC register, PC+1 adder, PC mux, synchronous instruction memory and IF/ID register.
- Generates PC write-enable, IF/ID write-enable, IF/ID flush, PC-mux select and ID/EX bubble.
- Handles post-reset memory warm-up, load-use stalls, taken-branch flushes, a HALT instruction, and a debug pause/single-step handshake.
- Sits beside the fetch stage and takes its hazard inputs from the ID stage.

---
 rtl/fetch_control_pkg.sv | 20 ++
 rtl/fetch_control_if.sv | 45 ++++
 rtl/fetch_control_hazard_detect.sv | 19 +
 rtl/fetch_control.sv | 132 +++++++++++++
 tb/tb_fetch_control.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_control_pkg.sv
// Shared definitions for the fetch-stage sequencing controller: FSM state
// encodings, datapath widths and the instruction constants used by the front end.
package fetch_control_pkg;

    localparam int PC_WIDTH = 11;
    localparam int REG_W    = 5;
    localparam int INSTR_W  = 32;

    localparam logic [5:0]         HALT_OPCODE = 6'h3F;
    localparam logic [INSTR_W-1:0] NOP_INSTR   = '0;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        STEP  = 3'd3,
        HALT  = 3'd4
    } state_t;

endpackage

// File: rtl/fetch_control_if.sv
// Bundle of hazard inputs from ID and control outputs toward the fetch datapath.
// The controller uses the master modport; the pipeline side uses slave.
interface fetch_control_if #(
    parameter int CNT_W = 16
);
    import fetch_control_pkg::*;

    logic                id_ex_mem_read;
    logic [REG_W-1:0]    id_ex_rt;
    logic [REG_W-1:0]    if_id_rs;
    logic [REG_W-1:0]    if_id_rt;
    logic                if_id_uses_rt;
    logic                branch_taken;
    logic [PC_WIDTH-1:0] branch_target;
    logic                halt_detected;
    logic                debug_mode;
    logic                step_req;

    logic                pc_write;
    logic                if_id_write;
    logic                if_flush;
    logic                id_ex_bubble;
    logic                pc_src;
    logic [PC_WIDTH-1:0] pc_salto;
    logic                step_ack;
    logic                halted;
    logic [2:0]          state_o;
    logic [CNT_W-1:0]    stall_count;
    logic [CNT_W-1:0]    flush_count;

    modport master (
        input  id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt,
               branch_taken, branch_target, halt_detected, debug_mode, step_req,
        output pc_write, if_id_write, if_flush, id_ex_bubble, pc_src, pc_salto,
               step_ack, halted, state_o, stall_count, flush_count
    );

    modport slave (
        output id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt,
               branch_taken, branch_target, halt_detected, debug_mode, step_req,
        input  pc_write, if_id_write, if_flush, id_ex_bubble, pc_src, pc_salto,
               step_ack, halted, state_o, stall_count, flush_count
    );

endinterface

// File: rtl/fetch_control_hazard_detect.sv
// Load-use hazard detector: flags when the load in ID/EX writes a register
// that the instruction in IF/ID is about to read. Register 0 never hazards.
module hazard_detect
    import fetch_control_pkg::*;
(
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] id_ex_rt,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             if_id_uses_rt,
    output logic             hz
);

    always_comb begin
        hz = id_ex_mem_read && (id_ex_rt != '0) &&
             ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
    end

endmodule

// File: rtl/fetch_control.sv
// Fetch-stage sequencer: boot warm-up, load-use stalls, branch flushes, HALT and
// debug pause/single-step. Control outputs are combinational from state and inputs.
module fetch_control
    import fetch_control_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic          clock,
    input  logic          reset,
    fetch_control_if.master bus
);

    localparam int               BOOT_W    = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BOOT_W-1:0] BOOT_INIT = BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t              state_q, state_d;
    logic [BOOT_W-1:0]   boot_cnt_q, boot_cnt_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic                hz;

    logic pc_write, if_id_write, if_flush, id_ex_bubble, pc_src, step_ack, halted;

    hazard_detect u_hazard (
        .id_ex_mem_read (bus.id_ex_mem_read),
        .id_ex_rt       (bus.id_ex_rt),
        .if_id_rs       (bus.if_id_rs),
        .if_id_rt       (bus.if_id_rt),
        .if_id_uses_rt  (bus.if_id_uses_rt),
        .hz             (hz)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= BOOT;
            boot_cnt_q  <= BOOT_INIT;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        boot_cnt_d   = boot_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_flush     = 1'b0;
        id_ex_bubble = 1'b0;
        pc_src       = 1'b0;
        step_ack     = 1'b0;
        halted       = 1'b0;

        case (state_q)
            BOOT: begin
                if_id_write  = 1'b1;
                if_flush     = 1'b1;
                id_ex_bubble = 1'b1;
                if (boot_cnt_q == '0) state_d = RUN;
                else                  boot_cnt_d = boot_cnt_q - 1'b1;
            end
            RUN, STEP: begin
                step_ack = (state_q == STEP);
                state_d  = bus.debug_mode ? PAUSE : RUN;
                // A stalled instruction is re-evaluated next cycle, so branch/HALT wait.
                if (hz) begin
                    id_ex_bubble = 1'b1;
                    if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
                end else if (bus.branch_taken) begin
                    pc_src      = 1'b1;
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    if_flush    = 1'b1;
                    if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
                end else if (bus.halt_detected) begin
                    state_d = HALT;
                end else begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                end
            end
            PAUSE: begin
                id_ex_bubble = 1'b1;
                if (!bus.debug_mode)   state_d = RUN;
                else if (bus.step_req) state_d = STEP;
            end
            HALT: begin
                id_ex_bubble = 1'b1;
                halted       = 1'b1;
            end
            default: begin
                if_id_write  = 1'b1;
                if_flush     = 1'b1;
                id_ex_bubble = 1'b1;
                state_d      = BOOT;
                boot_cnt_d   = BOOT_INIT;
            end
        endcase

        // Reset must drive the safe front-end values even before any clock edge.
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b1;
            if_flush     = 1'b1;
            id_ex_bubble = 1'b1;
            pc_src       = 1'b0;
            step_ack     = 1'b0;
            halted       = 1'b0;
        end
    end

    assign bus.pc_write     = pc_write;
    assign bus.if_id_write  = if_id_write;
    assign bus.if_flush     = if_flush;
    assign bus.id_ex_bubble = id_ex_bubble;
    assign bus.pc_src       = pc_src;
    assign bus.pc_salto     = pc_src ? bus.branch_target : '0;
    assign bus.step_ack     = step_ack;
    assign bus.halted       = halted;
    assign bus.state_o      = state_q;
    assign bus.stall_count  = stall_cnt_q;
    assign bus.flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_fetch_control.sv
// Self-checking bench for fetch_control: directed scenarios plus randomized
// traffic, all compared every cycle against a behavioural model of the rules.
module tb_fetch_control;

    localparam int BOOT_CYCLES = 2;
    localparam int CNT_W       = 16;
    localparam int CNT_SAT     = 65535;

    logic clock;
    logic reset;

    fetch_control_if #(.CNT_W(CNT_W)) bus ();

    fetch_control #(.BOOT_CYCLES(BOOT_CYCLES), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Model: 0=boot 1=run 2=pause 3=step 4=halt
    int m_state, m_boot, m_stall, m_flush;
    int n_state, n_boot, n_stall, n_flush;
    logic        e_pw, e_iw, e_fl, e_bub, e_src, e_ack, e_hlt;
    logic [10:0] e_salto;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic predict();
        bit hz, halt_fired;
        hz = bus.id_ex_mem_read && (bus.id_ex_rt != 0) &&
             ((bus.id_ex_rt == bus.if_id_rs) || (bus.if_id_uses_rt && (bus.id_ex_rt == bus.if_id_rt)));
        halt_fired = 0;
        {e_pw, e_iw, e_fl, e_bub, e_src, e_ack, e_hlt} = '0;
        e_salto = '0;
        n_state = m_state; n_boot = m_boot; n_stall = m_stall; n_flush = m_flush;
        if (reset) begin
            e_iw = 1; e_fl = 1; e_bub = 1;
            n_state = 0; n_boot = BOOT_CYCLES - 1; n_stall = 0; n_flush = 0;
        end else if (m_state == 0) begin
            e_iw = 1; e_fl = 1; e_bub = 1;
            if (m_boot == 0) n_state = 1; else n_boot = m_boot - 1;
        end else if (m_state == 1 || m_state == 3) begin
            e_ack = (m_state == 3);
            if (hz) begin
                e_bub = 1;
                n_stall = (m_stall < CNT_SAT) ? m_stall + 1 : CNT_SAT;
            end else if (bus.branch_taken) begin
                e_src = 1; e_salto = bus.branch_target; e_pw = 1; e_iw = 1; e_fl = 1;
                n_flush = (m_flush < CNT_SAT) ? m_flush + 1 : CNT_SAT;
            end else if (bus.halt_detected) begin
                halt_fired = 1;
            end else begin
                e_pw = 1; e_iw = 1;
            end
            n_state = halt_fired ? 4 : (bus.debug_mode ? 2 : 1);
        end else if (m_state == 2) begin
            e_bub = 1;
            if (!bus.debug_mode) n_state = 1;
            else if (bus.step_req) n_state = 3;
        end else begin
            e_bub = 1; e_hlt = 1;
        end
    endtask

    task automatic check_all();
        check("pc_write",     bus.pc_write,     e_pw);
        check("if_id_write",  bus.if_id_write,  e_iw);
        check("if_flush",     bus.if_flush,     e_fl);
        check("id_ex_bubble", bus.id_ex_bubble, e_bub);
        check("pc_src",       bus.pc_src,       e_src);
        check("pc_salto",     bus.pc_salto,     e_salto);
        check("step_ack",     bus.step_ack,     e_ack);
        check("halted",       bus.halted,       e_hlt);
        check("state_o",      bus.state_o,      m_state);
        check("stall_count",  bus.stall_count,  m_stall);
        check("flush_count",  bus.flush_count,  m_flush);
    endtask

    task automatic commit();
        m_state = n_state; m_boot = n_boot; m_stall = n_stall; m_flush = n_flush;
    endtask

    // Inputs are set at posedge+1; outputs are sampled at posedge+4.
    task automatic cycle();
        #3;
        predict();
        check_all();
        @(posedge clock);
        #1;
        commit();
    endtask

    task automatic set_idle();
        bus.id_ex_mem_read = 0; bus.id_ex_rt = 0; bus.if_id_rs = 0; bus.if_id_rt = 0;
        bus.if_id_uses_rt = 0; bus.branch_taken = 0; bus.branch_target = 0;
        bus.halt_detected = 0; bus.debug_mode = 0; bus.step_req = 0;
    endtask

    // Reset is raised mid-cycle so its effect is visibly asynchronous.
    task automatic do_reset();
        reset = 1;
        m_state = 0; m_boot = BOOT_CYCLES - 1; m_stall = 0; m_flush = 0;
        #2;
        predict();
        check_all();
        @(posedge clock);
        #1;
        commit();
        reset = 0;
    endtask

    initial begin
        reset = 1;
        set_idle();
        m_state = 0; m_boot = BOOT_CYCLES - 1; m_stall = 0; m_flush = 0;
        @(posedge clock);
        #1;
        do_reset();

        // Boot warm-up, then first RUN cycle
        cycle();
        cycle();
        check("boot_to_run", bus.state_o, 3'd1);
        cycle();

        // Load-use stall, then same with r0 destination
        bus.id_ex_mem_read = 1; bus.id_ex_rt = 5; bus.if_id_rs = 5;
        cycle();
        check("stall_count_one", bus.stall_count, 16'd1);
        bus.id_ex_rt = 0; bus.if_id_rs = 0;
        cycle();
        set_idle();

        // Taken branch, then branch coinciding with a hazard
        bus.branch_taken = 1; bus.branch_target = 11'h07A;
        #1;
        check("branch_salto", bus.pc_salto, 11'h07A);
        cycle();
        check("flush_count_one", bus.flush_count, 16'd1);
        bus.id_ex_mem_read = 1; bus.id_ex_rt = 7; bus.if_id_rt = 7; bus.if_id_uses_rt = 1;
        cycle();
        check("flush_unchanged", bus.flush_count, 16'd1);
        set_idle();

        // Debug pause and single step
        bus.debug_mode = 1;
        cycle();
        check("paused", bus.state_o, 3'd2);
        bus.step_req = 1;
        cycle();
        bus.step_req = 0;
        #1;
        check("step_ack_high", bus.step_ack, 1'b1);
        cycle();
        cycle();
        bus.debug_mode = 0;
        cycle();
        cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.id_ex_mem_read = 1'($urandom_range(0, 1));
            bus.id_ex_rt       = 5'($urandom_range(0, 3));
            bus.if_id_rs       = 5'($urandom_range(0, 3));
            bus.if_id_rt       = 5'($urandom_range(0, 3));
            bus.if_id_uses_rt  = 1'($urandom_range(0, 1));
            bus.branch_taken   = ($urandom_range(0, 3) == 0);
            bus.branch_target  = 11'($urandom_range(0, 2047));
            bus.halt_detected  = ($urandom_range(0, 79) == 0);
            bus.debug_mode     = ($urandom_range(0, 4) == 0);
            bus.step_req       = 1'($urandom_range(0, 1));
            cycle();
        end
        set_idle();
        do_reset();
        cycle();
        cycle();

        // HALT is sticky until reset
        bus.halt_detected = 1;
        cycle();
        bus.halt_detected = 0;
        check("halt_state", bus.state_o, 3'd4);
        for (int i = 0; i < 6; i++) begin
            bus.debug_mode = i[0];
            bus.step_req   = i[1];
            cycle();
        end
        check("still_halted", bus.halted, 1'b1);
        set_idle();
        do_reset();
        cycle();
        cycle();

        // Stall counter saturation, then async reset mid-stall
        bus.id_ex_mem_read = 1; bus.id_ex_rt = 9; bus.if_id_rs = 9;
        for (int i = 0; i < 70000; i++) cycle();
        check("stall_saturated", bus.stall_count, 16'hFFFF);
        do_reset();
        check("stall_cleared", bus.stall_count, 16'd0);
        set_idle();
        cycle();
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
